// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding constants: instruction classes, major opcodes and load-FSM states.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    ClsR    = 3'd0,
    ClsIAlu = 3'd1,
    ClsLw   = 3'd2,
    ClsSw   = 3'd3,
    ClsB    = 3'd4,
    ClsJal  = 3'd5
  } cls_e;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIAlu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [2:0] F3Word = 3'b010;
  localparam logic [2:0] F3Sll  = 3'b001;
  localparam logic [2:0] F3Sr   = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

  // funct7 as used by R-type and the immediate shifts: only bit 30 is variable.
  function automatic logic [6:0] funct7_of(input logic b5);
    return {1'b0, b5, 5'b00000};
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I word builder from decoded fields; JAL only when ENC_JAL_EN is defined.
module imm_pack
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic [6:0] f7;
  logic       is_shift;

  assign f7       = funct7_of(funct7b5);
  assign is_shift = (funct3 == F3Sll) || (funct3 == F3Sr);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (cls)
      ClsR: begin
        word = {f7, rs2, rs1, funct3, rd, OpcR};
      end
      ClsIAlu: begin
        if (is_shift) begin
          word = {f7, imm[4:0], rs1, funct3, rd, OpcIAlu};
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OpcIAlu};
        end
      end
      ClsLw: begin
        word = {imm[11:0], rs1, F3Word, rd, OpcLoad};
      end
      ClsSw: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpcStore};
      end
      ClsB: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpcBranch};
      end
`ifdef ENC_JAL_EN
      ClsJal: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
      end
`endif
      default: begin
        legal = 1'b0;
      end
    endcase
  end

`ifndef ENC_JAL_EN
  // Upper immediate bits only feed the J layout.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[20:13];
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32I words into an instruction memory, one session per start pulse.
// Optional JAL support is selected with the ENC_JAL_EN macro (see imm_pack).
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        cls,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [20:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [ADDR_W-1:0] AddrOne  = 1;
  localparam logic [ADDR_W:0]   CountOne = 1;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        wr_done;
  logic        accept;

  imm_pack u_imm_pack (
    .cls      (cls),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .imm      (imm),
    .word     (enc_word),
    .legal    (enc_legal)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;

    wr_done = we_q && mem_ready;
    // No room for a new word while the final address is still being written.
    in_ready = (state_q == StLoad) && !start &&
               (!we_q || (mem_ready && (addr_q != LastAddr)));
    accept = in_valid && in_ready;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (wr_done) begin
          we_d    = 1'b0;
          addr_d  = addr_q + AddrOne;
          count_d = count_q + CountOne;
          if (addr_q == LastAddr) begin
            state_d = StDone;
          end
        end
        if (accept) begin
          if (enc_legal) begin
            we_d    = 1'b1;
            wdata_d = enc_word;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign full      = (state_q == StDone);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, directed corner sequences, random vs model.
module tb_instr_encoder;

  localparam int unsigned AW    = 2;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, mem_ready;
  logic          in_ready, mem_we, full, err;
  logic [2:0]    cls, funct3;
  logic [4:0]    rd, rs1, rs2;
  logic          funct7b5;
  logic [20:0]   imm;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cls       (cls),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .full      (full),
    .err       (err),
    .count     (count)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [20:0] imm;
    logic [31:0] word;
    logic        legal;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f, input logic b5,
                              input logic [20:0] im, input logic [31:0] w, input logic lg);
    vec_t v;
    v.cls = c; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f; v.f7b5 = b5; v.imm = im;
    v.word = w; v.legal = lg;
    return v;
  endfunction

  // Reference encoder built from bit positions with plain arithmetic; returns {legal, word}.
  function automatic logic [32:0] ref_enc(input int unsigned c, input int unsigned d,
                                          input int unsigned s1, input int unsigned s2,
                                          input int unsigned f, input int unsigned b5,
                                          input int unsigned i);
    int unsigned w;
    int unsigned base_rs;
    base_rs = (s1 << 15) | (f << 12);
    w = 0;
    case (c)
      0: return {1'b1, 32'((b5 << 30) | (s2 << 20) | base_rs | (d << 7) | 32'h33)};
      1: begin
        if (f == 1 || f == 5) w = (b5 << 30) | ((i % 32) << 20);
        else w = (i % 4096) << 20;
        return {1'b1, 32'(w | base_rs | (d << 7) | 32'h13)};
      end
      2: return {1'b1, 32'(((i % 4096) << 20) | (s1 << 15) | (2 << 12) | (d << 7) | 32'h03)};
      3: return {1'b1, 32'((((i / 32) % 128) << 25) | (s2 << 20) | base_rs |
                           ((i % 32) << 7) | 32'h23)};
      4: return {1'b1, 32'((((i / 4096) % 2) << 31) | (((i / 32) % 64) << 25) | (s2 << 20) |
                           base_rs | (((i / 2) % 16) << 8) | (((i / 2048) % 2) << 7) |
                           32'h63)};
`ifdef ENC_JAL_EN
      5: return {1'b1, 32'((((i / 1048576) % 2) << 31) | (((i / 2) % 1024) << 21) |
                           (((i / 2048) % 2) << 20) | (((i / 4096) % 256) << 12) |
                           (d << 7) | 32'h6F)};
`endif
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic set_fields(input vec_t v);
    cls = v.cls; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7b5 = v.f7b5; imm = v.imm;
  endtask

  // Presents a bundle until accepted; returns one cycle after the handshake edge.
  task automatic send(input vec_t v);
    logic got;
    got = 1'b0;
    set_fields(v);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 32'(got), 32'd1);
  endtask

  vec_t v_r, v_sw, v_b;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cls = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7b5 = 1'b0; imm = '0;
    vecs[0] = mk(3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1, 21'h0, 32'h407302B3, 1'b1);
    vecs[1] = mk(3'd3, 5'd31, 5'd2, 5'd8, 3'd2, 1'b0, 21'h1FFFFC, 32'hFE812E23, 1'b1);
    vecs[2] = mk(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd16, 32'h00208863, 1'b1);
    vecs[3] = mk(3'd2, 5'd3, 5'd4, 5'd9, 3'd7, 1'b1, 21'd12, 32'h00C22183, 1'b1);
    vecs[4] = mk(3'd1, 5'd1, 5'd0, 5'd31, 3'd0, 1'b1, 21'h1FFFFF, 32'hFFF00093, 1'b1);
    vecs[5] = mk(3'd1, 5'd2, 5'd3, 5'd0, 3'd5, 1'b1, 21'h1FFFE3, 32'h4031D113, 1'b1);
    vecs[6] = mk(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 21'd4, 32'h0, 1'b0);
    vecs[7] = mk(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 21'd4, 32'h0, 1'b0);
    vecs[8] = mk(3'd4, 5'd31, 5'd1, 5'd2, 3'd0, 1'b1, 21'h0FE010, 32'h00208863, 1'b1);
`ifdef ENC_JAL_EN
    vecs[9] = mk(3'd5, 5'd1, 5'd9, 5'd9, 3'd3, 1'b0, 21'd8, 32'h008000EF, 1'b1);
`else
    vecs[9] = mk(3'd5, 5'd1, 5'd9, 5'd9, 3'd3, 1'b0, 21'd8, 32'h0, 1'b0);
`endif

    do_reset();
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(in_ready), 0);

    // Vector table: one word per fresh session.
    foreach (vecs[n]) begin
      do_reset();
      pulse_start();
      send(vecs[n]);
      if (vecs[n].legal) begin
        chk($sformatf("vec%0d_we", n), 32'(mem_we), 1);
        chk($sformatf("vec%0d_addr", n), 32'(mem_addr), 0);
        chk($sformatf("vec%0d_wdata", n), mem_wdata, vecs[n].word);
        chk($sformatf("vec%0d_err", n), 32'(err), 0);
        step();
        chk($sformatf("vec%0d_count", n), 32'(count), 1);
        chk($sformatf("vec%0d_we_clr", n), 32'(mem_we), 0);
      end else begin
        chk($sformatf("vec%0d_nowe", n), 32'(mem_we), 0);
        chk($sformatf("vec%0d_err", n), 32'(err), 1);
        chk($sformatf("vec%0d_ptr", n), 32'(mem_addr), 0);
        chk($sformatf("vec%0d_count", n), 32'(count), 0);
      end
    end

    v_r  = vecs[0];
    v_sw = vecs[1];
    v_b  = vecs[2];

    // Backpressure: word held for three stalled cycles, then one write.
    do_reset();
    pulse_start();
    mem_ready = 1'b0;
    send(v_sw);
    set_fields(v_r);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_we", 32'(mem_we), 1);
      chk("bp_wdata", mem_wdata, 32'hFE812E23);
      chk("bp_addr", 32'(mem_addr), 0);
      chk("bp_ready", 32'(in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    mem_ready = 1'b1;
    step();
    chk("bp_count", 32'(count), 1);
    chk("bp_we_clr", 32'(mem_we), 0);
    chk("bp_addr_next", 32'(mem_addr), 1);

    // B after two writes, plus an illegal bundle leaving the pointer alone.
    do_reset();
    pulse_start();
    send(v_r);
    send(v_r);
    send(v_b);
    chk("b_addr", 32'(mem_addr), 2);
    chk("b_wdata", mem_wdata, 32'h00208863);
    step();
    chk("b_count", 32'(count), 3);
    send(vecs[6]);
    chk("ill_nowe", 32'(mem_we), 0);
    chk("ill_err", 32'(err), 1);
    chk("ill_addr", 32'(mem_addr), 3);
    chk("ill_count", 32'(count), 3);

    // Fill and wrap, then restart with start and in_valid together.
    do_reset();
    pulse_start();
    for (int k = 0; k < Depth; k++) send(v_r);
    in_valid = 1'b1;
    #1;
    chk("fill_last_ready", 32'(in_ready), 0);
    chk("fill_last_addr", 32'(mem_addr), Depth - 1);
    step();
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), Depth);
    chk("fill_ready", 32'(in_ready), 0);
    chk("fill_we", 32'(mem_we), 0);
    start = 1'b1;
    #1;
    chk("st_iv_ready", 32'(in_ready), 0);
    step();
    start = 1'b0;
    in_valid = 1'b0;
    chk("wrap_full", 32'(full), 0);
    chk("wrap_count", 32'(count), 0);
    chk("wrap_addr", 32'(mem_addr), 0);
    chk("wrap_noacc", 32'(mem_we), 0);

    // Start is ignored while a write is stalled.
    do_reset();
    pulse_start();
    mem_ready = 1'b0;
    send(v_r);
    pulse_start();
    chk("stp_we", 32'(mem_we), 1);
    mem_ready = 1'b1;
    step();
    chk("stp_count", 32'(count), 1);
    chk("stp_addr", 32'(mem_addr), 1);

    // Reset mid-write discards the pending word.
    do_reset();
    pulse_start();
    mem_ready = 1'b0;
    send(v_r);
    chk("rmw_we_pre", 32'(mem_we), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmw_we", 32'(mem_we), 0);
    chk("rmw_wdata", mem_wdata, 0);
    chk("rmw_addr", 32'(mem_addr), 0);
    chk("rmw_count", 32'(count), 0);
    chk("rmw_err", 32'(err), 0);
    chk("rmw_full", 32'(full), 0);
    chk("rmw_ready", 32'(in_ready), 0);
    mem_ready = 1'b1;
    step();
    chk("rmw_idle_we", 32'(mem_we), 0);

    // Random traffic against the behavioural model.
    begin
      logic [31:0] q[$];
      logic [32:0] r;
      bit          sess_open;
      int          done_cnt;
      int          exp_addr;
      bit          exp_err;
      bit          acc, wr;
      do_reset();
      sess_open = 1'b0; done_cnt = 0; exp_addr = 0; exp_err = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        in_valid  = ($urandom_range(0, 2) != 0);
        cls       = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7b5 = 1'($urandom); imm = 21'($urandom);
        start = (!sess_open || done_cnt == Depth) && ($urandom_range(0, 3) == 0);
        #1;
        chk("rnd_we", 32'(mem_we), 32'(q.size() != 0));
        if (q.size() != 0) begin
          chk("rnd_addr", 32'(mem_addr), 32'(exp_addr));
          chk("rnd_wdata", mem_wdata, q[0]);
        end
        chk("rnd_count", 32'(count), 32'(done_cnt));
        chk("rnd_err", 32'(err), 32'(exp_err));
        chk("rnd_full", 32'(full), 32'(sess_open && done_cnt == Depth));
        if (!sess_open || done_cnt == Depth || start || (q.size() != 0 && !mem_ready))
          chk("rnd_ready_lo", 32'(in_ready), 0);
        else if (q.size() == 0 || exp_addr != Depth - 1)
          chk("rnd_ready_hi", 32'(in_ready), 1);
        acc = in_valid && in_ready;
        wr  = mem_we && mem_ready;
        if (wr && q.size() != 0) begin
          void'(q.pop_front());
          done_cnt++;
          exp_addr = (exp_addr + 1) % Depth;
        end
        if (acc) begin
          r = ref_enc(cls, rd, rs1, rs2, funct3, funct7b5, imm);
          if (r[32]) q.push_back(r[31:0]);
          else exp_err = 1'b1;
        end
        if (start) begin
          sess_open = 1'b1; done_cnt = 0; exp_addr = 0; exp_err = 1'b0;
        end
        step();
      end
      start = 1'b0;
      in_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, instruction-memory word-address width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- cls  in  3  class: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 B, 5 JAL.
- rd / rs1 / rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7b5  in  1  instruction bit 30.
- imm  in  21  signed immediate.
- mem_we  out  1  write request to instruction memory.
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded RV32I word.
- full  out  1  memory filled; session ended.
- err  out  1  sticky flag; an illegal class was dropped.
- count  out  ADDR_W+1  words written this session.

Function
REQ-003 SHALL run FSM IDLE -> LOAD on start; LOAD -> DONE after the write to address 2^ADDR_W-1 completes; DONE -> LOAD on start.
REQ-004 SHALL drive in_ready=1 only in LOAD, and only when !mem_we || mem_ready.
REQ-005 SHALL register the encoded word on acceptance and assert mem_we the next cycle (latency 1).
REQ-006 SHALL hold mem_we, mem_addr and mem_wdata stable while mem_ready=0.
REQ-007 SHALL sustain one word per cycle while mem_ready=1.
REQ-008 SHALL encode each class with these opcodes and fields:
- R: 0110011; funct7 = {0,funct7b5,00000}.
- I-ALU: 0010011; imm[11:0].
  - When funct3=001 or 101, bits[31:25] = {0,funct7b5,00000} and bits[24:20] = imm[4:0].
- LW: 0000011; funct3 forced to 010.
- SW: 0100011; S-split of imm[11:0].
- B: 1100011; imm[12:1] in B layout.
- JAL: 1101111; imm[20:1] in J layout.
REQ-009 SHALL ignore immediate bits above each format's range.
REQ-010 SHALL ignore the rd, rs1 and rs2 fields not used by the format.
REQ-011 SHALL accept and drop an illegal class (6, 7, or 5 when the macro is absent): no write, err set, pointer unchanged.
REQ-012 SHALL advance mem_addr by 1 per completed write.
REQ-013 SHALL drive count equal to the number of completed writes in the session.
REQ-014 SHALL assert full in DONE, with in_ready=0.
REQ-015 SHALL ignore start while LOAD has a write pending.
REQ-016 SHALL restart on start in IDLE or DONE: clear pointer, count, full and err.
REQ-017 SHALL treat start and in_valid in the same cycle as start only; no accept that cycle.

Reset
REQ-018 SHALL, on rst=1 at a clock edge, enter IDLE with:
- mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, in_ready=0.
REQ-019 SHALL discard any pending write when reset is asserted mid-session.

Configuration
REQ-020 SHALL compile JAL (class 5) encoding only when ENC_JAL_EN is defined.
REQ-021 SHALL, without ENC_JAL_EN, treat class 5 as illegal per REQ-011.

Structure
REQ-022 SHALL place opcode constants, class codes and FSM state encodings in shared package riscv_enc_pkg, also imported by the decoders.
REQ-023 SHALL use a combinational sub-module imm_pack that forms the 32-bit word from fields and class.
REQ-024 SHALL keep the FSM, output register and pointer in instr_encoder.

Verification
REQ-025 Bench SHALL cover these scenarios:
- R encoding: start, then R rd=5, rs1=6, rs2=7, funct3=0, funct7b5=1 -> next cycle mem_we=1, addr 0, wdata 0x407302B3.
- Backpressure: SW rs1=2, rs2=8, imm=-4, with mem_ready=0 for 3 cycles -> wdata 0xFE812E23 held stable, in_ready=0; one write at addr 0 on release.
- B encoding: B rs1=1, rs2=2, funct3=0, imm=16 after two prior writes -> addr 2, wdata 0x00208863; count 3 after write.
- Fill and wrap (ADDR_W=2): 4 back-to-back writes -> full=1 after 4th, in_ready=0; start -> addr 0, count 0, full 0.
- Illegal class: cls=6 -> err=1, no mem_we, pointer unchanged.
  - cls=5 with ENC_JAL_EN, rd=1, imm=8 -> wdata 0x008000EF.
  - cls=5 without the macro -> err=1.
- Reset mid-write: rst while mem_we=1, mem_ready=0 -> next cycle all outputs 0, IDLE.
